// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with fixed-length burst protection and locked transfers.
// All state advances only on hready=1 edges; reset parks the bus on master 0.
module ahb_arbiter #(
  parameter int N_MSTR = 4,
  parameter int MW     = 2
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic [N_MSTR-1:0] hbusreq,
  input  logic [N_MSTR-1:0] hlock,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hburst,
  input  logic              hready,
  output logic [N_MSTR-1:0] hgrant,
  output logic [MW-1:0]     hmaster,
  output logic [MW-1:0]     hmaster_d,
  output logic              hmastlock
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } trans_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [N_MSTR-1:0]   grant_q, grant_d;
  logic [MW-1:0]       master_q, master_d;
  logic [MW-1:0]       master_dp_q;
  logic                mastlock_q;

  logic [MW-1:0]       rr_idx;
  logic                rr_found;
  logic [3:0]          burst_len_m1;
  logic                burst_start;
  logic                owner_locked;
  logic                do_arb;
  trans_e              trans;

  assign trans        = trans_e'(htrans);
  assign burst_start  = (trans == TR_NONSEQ) && (hburst[2:1] != 2'b00);
  assign owner_locked = hlock[master_q] && hbusreq[master_q];

  always_comb begin
    case (hburst[2:1])
      2'b01:   burst_len_m1 = 4'd3;
      2'b10:   burst_len_m1 = 4'd7;
      2'b11:   burst_len_m1 = 4'd15;
      default: burst_len_m1 = 4'd0;
    endcase
  end

  // Round-robin search begins just after the current owner and wraps back to it last.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= N_MSTR; k++) begin
      logic [MW-1:0] cand;
      cand = MW'((int'(master_q) + k) % N_MSTR);
      if (!rr_found && hbusreq[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Next state assumes the transfer is accepted; the register bank only loads when hready=1.
  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    master_d = master_q;
    do_arb   = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (burst_start && !owner_locked) begin
          state_d = ST_BURST;
          cnt_d   = burst_len_m1;
        end else begin
          do_arb = 1'b1;
        end
      end

      ST_BURST: begin
        case (trans)
          TR_SEQ: begin
            if (cnt_q <= 4'd1) begin
              do_arb = 1'b1;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
          TR_BUSY: ;
          default: do_arb = 1'b1;
        endcase
      end

      ST_LOCK: begin
        if (!hlock[master_q] && (trans == TR_IDLE || trans == TR_NONSEQ)) begin
          do_arb = 1'b1;
        end else begin
          case (trans)
            TR_NONSEQ: cnt_d = burst_start ? burst_len_m1 : 4'd0;
            TR_SEQ:    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
            TR_IDLE:   cnt_d = 4'd0;
            default:   ;
          endcase
        end
      end

      default: begin
        state_d = ST_ARB;
        cnt_d   = 4'd0;
      end
    endcase

    // A locked owner that still requests keeps the bus; a burst it starts is tracked under LOCK.
    if (do_arb) begin
      if (owner_locked) begin
        state_d  = ST_LOCK;
        master_d = master_q;
        cnt_d    = burst_start ? burst_len_m1 : 4'd0;
      end else begin
        state_d  = ST_ARB;
        master_d = rr_idx;
        cnt_d    = 4'd0;
      end
    end
  end

  always_comb begin
    grant_d           = '0;
    grant_d[master_d] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= ST_ARB;
      cnt_q       <= 4'd0;
      grant_q     <= N_MSTR'(1);
      master_q    <= '0;
      master_dp_q <= '0;
      mastlock_q  <= 1'b0;
    end else if (hready) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      master_q    <= master_d;
      master_dp_q <= master_q;
      mastlock_q  <= hlock[master_d];
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = master_q;
  assign hmaster_d = master_dp_q;
  assign hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: round-robin, bursts with BUSY/wait, early termination,
// locking, parking and asynchronous reset mid-burst.
module tb_ahb_arbiter;

  localparam int N  = 4;
  localparam int MW = 2;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;

  logic          hclk = 1'b0;
  logic          hreset_n;
  logic [N-1:0]  hbusreq, hlock;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic          hready;
  logic [N-1:0]  hgrant;
  logic [MW-1:0] hmaster, hmaster_d;
  logic          hmastlock;

  int checks   = 0;
  int failures = 0;

  ahb_arbiter #(.N_MSTR(N), .MW(MW)) dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    tick();
  endtask

  typedef struct {
    logic [1:0]   tr;
    logic         rdy;
    logic [N-1:0] grant;
  } vec_t;

  vec_t incr8_tbl[11];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hreset_n = 1'b0;
    hbusreq  = '0;
    hlock    = '0;
    htrans   = IDLE;
    hburst   = 3'd0;
    hready   = 1'b1;
    #12;
    check("rst_grant", 32'(hgrant), 32'h1);
    check("rst_hmaster", 32'(hmaster), 32'h0);
    check("rst_hmaster_d", 32'(hmaster_d), 32'h0);
    check("rst_mastlock", 32'(hmastlock), 32'h0);
    hreset_n = 1'b1;

    // No requests: parked on master 0.
    drive(4'b0000, 4'b0000, IDLE, 3'd0, 1'b1);
    check("park_grant", 32'(hgrant), 32'h1);

    // Round-robin between masters 1 and 2 with SINGLE transfers.
    drive(4'b0110, 4'b0000, NONSEQ, 3'd0, 1'b1);
    check("rr1_grant", 32'(hgrant), 32'h2);
    check("rr1_hmaster_d", 32'(hmaster_d), 32'h0);
    drive(4'b0110, 4'b0000, NONSEQ, 3'd0, 1'b1);
    check("rr2_grant", 32'(hgrant), 32'h4);
    check("rr2_hmaster", 32'(hmaster), 32'h2);
    check("rr2_hmaster_d", 32'(hmaster_d), 32'h1);
    drive(4'b0110, 4'b0000, NONSEQ, 3'd0, 1'b1);
    check("rr3_grant", 32'(hgrant), 32'h2);
    check("rr3_hmaster_d", 32'(hmaster_d), 32'h2);

    // hready low: everything holds even though requests changed.
    drive(4'b1000, 4'b0000, NONSEQ, 3'd0, 1'b0);
    check("wait_grant", 32'(hgrant), 32'h2);
    check("wait_hmaster_d", 32'(hmaster_d), 32'h2);

    // INCR4 by master 1: held for NONSEQ + 2 SEQ, moves on the third SEQ.
    drive(4'b1110, 4'b0000, NONSEQ, 3'd3, 1'b1);
    check("incr4_ns", 32'(hgrant), 32'h2);
    drive(4'b1110, 4'b0000, SEQ, 3'd3, 1'b1);
    check("incr4_s1", 32'(hgrant), 32'h2);
    drive(4'b1110, 4'b0000, SEQ, 3'd3, 1'b1);
    check("incr4_s2", 32'(hgrant), 32'h2);
    drive(4'b1110, 4'b0000, SEQ, 3'd3, 1'b1);
    check("incr4_s3", 32'(hgrant), 32'h4);
    check("incr4_hmaster", 32'(hmaster), 32'h2);

    // INCR8 by master 2 with two BUSY cycles and one wait state.
    incr8_tbl = '{
      '{NONSEQ, 1'b1, 4'b0100}, '{SEQ,  1'b1, 4'b0100}, '{BUSY, 1'b1, 4'b0100},
      '{SEQ,    1'b1, 4'b0100}, '{SEQ,  1'b0, 4'b0100}, '{SEQ,  1'b1, 4'b0100},
      '{BUSY,   1'b1, 4'b0100}, '{SEQ,  1'b1, 4'b0100}, '{SEQ,  1'b1, 4'b0100},
      '{SEQ,    1'b1, 4'b0100}, '{SEQ,  1'b1, 4'b1000}
    };
    for (int i = 0; i < 11; i++) begin
      drive(4'b1110, 4'b0000, incr8_tbl[i].tr, 3'd5, incr8_tbl[i].rdy);
      check($sformatf("incr8_step%0d", i), 32'(hgrant), 32'(incr8_tbl[i].grant));
    end

    // Early termination of INCR16 by master 0 after two beats.
    drive(4'b0001, 4'b0000, IDLE, 3'd0, 1'b1);
    check("et_own0", 32'(hgrant), 32'h1);
    drive(4'b1001, 4'b0000, NONSEQ, 3'd7, 1'b1);
    check("et_ns", 32'(hgrant), 32'h1);
    drive(4'b1001, 4'b0000, SEQ, 3'd7, 1'b1);
    check("et_s1", 32'(hgrant), 32'h1);
    drive(4'b1001, 4'b0000, NONSEQ, 3'd7, 1'b1);
    check("et_term", 32'(hgrant), 32'h8);

    // Locked master 2 holds the bus over 5 SINGLE transfers, then releases with IDLE.
    drive(4'b0100, 4'b0000, IDLE, 3'd0, 1'b1);
    check("lk_own2", 32'(hgrant), 32'h4);
    check("lk_mastlock0", 32'(hmastlock), 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b0100, NONSEQ, 3'd0, 1'b1);
      check($sformatf("lk_grant%0d", i), 32'(hgrant), 32'h4);
      check($sformatf("lk_mastlock%0d", i), 32'(hmastlock), 32'h1);
    end
    drive(4'b1111, 4'b0000, IDLE, 3'd0, 1'b1);
    check("lk_release", 32'(hgrant), 32'h8);
    check("lk_release_ml", 32'(hmastlock), 32'h0);

    // Reset asserted during beat 5 of a WRAP16 by master 3.
    drive(4'b1111, 4'b0000, NONSEQ, 3'd6, 1'b1);
    check("w16_ns", 32'(hgrant), 32'h8);
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 4'b0000, SEQ, 3'd6, 1'b1);
      check($sformatf("w16_s%0d", i + 1), 32'(hgrant), 32'h8);
    end
    htrans = SEQ;
    #2 hreset_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(hgrant), 32'h1);
    check("mid_rst_hmaster", 32'(hmaster), 32'h0);
    check("mid_rst_mastlock", 32'(hmastlock), 32'h0);
    check("mid_rst_hmaster_d", 32'(hmaster_d), 32'h0);
    #2 hreset_n = 1'b1;

    // After reset the arbiter is back in ARB with a cleared counter.
    drive(4'b1111, 4'b0000, IDLE, 3'd0, 1'b1);
    check("post_rst_arb1", 32'(hgrant), 32'h2);
    drive(4'b1111, 4'b0000, SEQ, 3'd0, 1'b1);
    check("post_rst_arb2", 32'(hgrant), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
